// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointers.
// Functions operate on a zero-extended MAX_W vector, so one definition serves every width.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int MAX_W              = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Upper bits of a narrower value are zero, so the prefix XOR from the top is exact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    bin[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Free-running Gray-code pointer with enable, synchronous active-low clear and wrap pulse.
// All outputs come straight from flops so the Gray value can be sampled in another domain.
module gray_counter
  import gray_pkg::*;
#(
  parameter int COUNTER_WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Clear_in,
  input  logic                     Enable_in,
  output logic [COUNTER_WIDTH-1:0] GrayCount_out,
  output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
  output logic                     Wrap_out
);

  localparam int W = COUNTER_WIDTH;

  generate
    if (W < 2 || W > MAX_W) begin : g_bad_width
      $error("gray_counter: COUNTER_WIDTH must be in 2..MAX_W");
    end
  endgenerate

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q + 1'b1;
    gray_d = W'(bin2gray(MAX_W'(bin_d)));
    // Stepping from the all-ones binary count is the step back to Gray zero.
    wrap_d = &bin_q;
  end

  always_ff @(posedge Clk) begin
    if (!Clear_in) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else if (Enable_in) begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign GrayCount_out   = gray_q;
  assign BinaryCount_out = bin_q;
  assign Wrap_out        = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomised and directed check of gray_counter at widths 2, 4 and 6 against a counting model.
module tb_gray_counter;

  logic clk = 1'b0;
  logic clear_n;
  logic enable;

  logic [1:0] g2, b2;
  logic [3:0] g4, b4;
  logic [5:0] g6, b6;
  logic       w2, w4, w6;

  int total = 0;
  int bad   = 0;

  int widths [3] = '{2, 4, 6};
  int cnt    [3];
  int wrap_e [3];
  int prev_g [3];

  // Expected W=4 sequence written out by hand.
  int gray4_tbl [16] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4,
                         'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8};

  always #5 clk = ~clk;

  gray_counter #(.COUNTER_WIDTH(2)) u_w2 (
    .Clk(clk), .Clear_in(clear_n), .Enable_in(enable),
    .GrayCount_out(g2), .BinaryCount_out(b2), .Wrap_out(w2)
  );
  gray_counter #(.COUNTER_WIDTH(4)) u_w4 (
    .Clk(clk), .Clear_in(clear_n), .Enable_in(enable),
    .GrayCount_out(g4), .BinaryCount_out(b4), .Wrap_out(w4)
  );
  gray_counter #(.COUNTER_WIDTH(6)) u_w6 (
    .Clk(clk), .Clear_in(clear_n), .Enable_in(enable),
    .GrayCount_out(g6), .BinaryCount_out(b6), .Wrap_out(w6)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_of(input int k);
    case (k)
      0:       return int'(g2);
      1:       return int'(g4);
      default: return int'(g6);
    endcase
  endfunction

  function automatic int bin_of(input int k);
    case (k)
      0:       return int'(b2);
      1:       return int'(b4);
      default: return int'(b6);
    endcase
  endfunction

  function automatic int wrap_of(input int k);
    case (k)
      0:       return int'(w2);
      1:       return int'(w4);
      default: return int'(w6);
    endcase
  endfunction

  // Apply one edge of stimulus, advance the model, compare every instance.
  task automatic step(input logic clr_n_v, input logic en_v, input bit verbose);
    int period, g, exp_g;
    string tag;
    clear_n = clr_n_v;
    enable  = en_v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      period = 1 << widths[k];
      if (!clr_n_v) begin
        cnt[k]    = 0;
        wrap_e[k] = 0;
      end else if (en_v) begin
        wrap_e[k] = (cnt[k] == period - 1) ? 1 : 0;
        cnt[k]    = (cnt[k] + 1) % period;
      end else begin
        wrap_e[k] = 0;
      end
      exp_g = cnt[k] ^ (cnt[k] / 2);
      g     = gray_of(k);
      tag   = $sformatf("w%0d", widths[k]);
      check({tag, "_gray"}, g, exp_g);
      check({tag, "_bin"}, bin_of(k), cnt[k]);
      check({tag, "_wrap"}, wrap_of(k), wrap_e[k]);
      if (clr_n_v && en_v)
        check({tag, "_onebit"}, $countones(prev_g[k] ^ g), 1);
      prev_g[k] = g;
    end
    check("w4_table", gray_of(1), gray4_tbl[cnt[1]]);
    if (verbose)
      $display("step clr_n=%0b en=%0b | w2 g=%0h | w4 g=%0h b=%0h wrap=%0b | w6 g=%0h",
               clr_n_v, en_v, g2, g4, b4, w4, g6);
  endtask

  initial begin
    clear_n = 1'b0;
    enable  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; wrap_e[k] = 0; prev_g[k] = 0;
    end

    // Clear with enable high for three cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // One full W=4 period, including the wrap back to zero.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1);

    // Advance to Gray 6, then hold for five cycles and re-enable to 7.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    check("at_six", int'(g4), 'h6);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("after_hold", int'(g4), 'h7);

    // Advance to Gray D, clear with enable high, then first enable gives 1.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    check("at_d", int'(g4), 'hD);
    step(1'b0, 1'b1, 1'b1);
    check("mid_clear", int'(g4), 0);
    check("mid_clear_wrap", int'(w4), 0);
    step(1'b1, 1'b1, 1'b1);
    check("first_after_clear", int'(g4), 1);

    // A full W=6 period plus one step past its wrap.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65; i++) step(1'b1, 1'b1, 1'b0);
    check("w6_period", int'(g6), 1);

    // Random enables with occasional clears.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 49) != 0), $urandom_range(0, 3) != 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
